// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeating it
// rep+1 times with a fixed idle gap between sends, under a start/busy/done handshake.
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       start,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    input  logic [CNT_W-1:0]           rep,
    input  logic                       abort,
    output logic                       x,
    output logic                       valid,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 S
);

    localparam int unsigned LW       = $clog2(WIDTH + 1);
    localparam int unsigned BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2,
        StDone  = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   pat_q;
    logic [BW-1:0]      last_q;
    logic [BW-1:0]      bitcnt;
    logic [CNT_W-1:0]   repcnt;
    logic [GW-1:0]      gapcnt;
    logic [BW-1:0]      len_m1;

    assign S = state;

    // Out-of-range or zero length selects the full pattern width.
    always_comb begin
        if (len == '0 || len > LW'(WIDTH)) begin
            len_m1 = BW'(WIDTH - 1);
        end else begin
            len_m1 = BW'(len - LW'(1));
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= StIdle;
            pat_q  <= '0;
            last_q <= '0;
            bitcnt <= '0;
            repcnt <= '0;
            gapcnt <= '0;
            x      <= 1'b0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (abort && state != StIdle) begin
            state <= StIdle;
            x     <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    x     <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        pat_q  <= pattern;
                        last_q <= len_m1;
                        bitcnt <= len_m1;
                        repcnt <= rep;
                        state  <= StShift;
                        x      <= pattern[len_m1];
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                StShift: begin
                    if (bitcnt == '0) begin
                        if (repcnt == '0) begin
                            state <= StDone;
                            x     <= 1'b0;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            repcnt <= repcnt - CNT_W'(1);
                            bitcnt <= last_q;
                            if (GAP == 0) begin
                                x     <= pat_q[last_q];
                                valid <= 1'b1;
                            end else begin
                                state  <= StGap;
                                gapcnt <= GW'(GAP_LOAD);
                                x      <= 1'b0;
                                valid  <= 1'b0;
                            end
                        end
                    end else begin
                        bitcnt <= bitcnt - BW'(1);
                        x      <= pat_q[bitcnt - BW'(1)];
                    end
                end
                StGap: begin
                    if (gapcnt == '0) begin
                        state <= StShift;
                        x     <= pat_q[bitcnt];
                        valid <= 1'b1;
                    end else begin
                        gapcnt <= gapcnt - GW'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx (WIDTH=8, GAP=2, CNT_W=4) with
// hand-computed bit streams and handshake expectations.
module tb_serial_pattern_tx;

    logic       CLK;
    logic       RESET_N;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] rep;
    logic       abort;
    logic       x;
    logic       valid;
    logic       busy;
    logic       done;
    logic [1:0] S;

    int vectors;
    int miscompares;

    serial_pattern_tx #(
        .WIDTH(8),
        .GAP  (2),
        .CNT_W(4)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .start  (start),
        .pattern(pattern),
        .len    (len),
        .rep    (rep),
        .abort  (abort),
        .x      (x),
        .valid  (valid),
        .busy   (busy),
        .done   (done),
        .S      (S)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        pattern = p;
        len     = l;
        rep     = r;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        rep     = '0;
        #3;
        vectors++;
        if (S !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_S: got %0d want 0", S);
        end
        vectors++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outs: got x/valid/busy/done=%b want 0000", {x, valid, busy, done});
        end
        #9;
        RESET_N = 1'b1;
        step();
        vectors++;
        if (S !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got S=%0d busy=%b want S=0 busy=0", S, busy);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        launch(8'b0000_1011, 4'd4, 4'd0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({x, valid, busy, S} !== {exp_bits[3-i], 1'b1, 1'b1, 2'd1}) begin
                miscompares++;
                $display("FAIL single_bit%0d: got x=%b valid=%b busy=%b S=%0d want x=%b valid=1 busy=1 S=1",
                         i, x, valid, busy, S, exp_bits[3-i]);
            end
            step();
        end
        vectors++;
        if ({done, busy, x, S} !== {1'b1, 1'b0, 1'b0, 2'd3}) begin
            miscompares++;
            $display("FAIL single_done: got done=%b busy=%b x=%b S=%0d want done=1 busy=0 x=0 S=3",
                     done, busy, x, S);
        end
        step();
        vectors++;
        if (done !== 1'b0 || S !== 2'd0) begin
            miscompares++;
            $display("FAIL single_back_idle: got done=%b S=%0d want done=0 S=0", done, S);
        end
    endtask

    task automatic test_repeat_gap();
        logic [15:0] exp_x;
        logic [15:0] exp_v;
        int          busy_cnt;
        int          done_cnt;
        exp_x    = 16'b1011_00_1011_00_1011;
        exp_v    = 16'b1111_00_1111_00_1111;
        busy_cnt = 0;
        done_cnt = 0;
        launch(8'b0000_1011, 4'd4, 4'd2);
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                vectors++;
                if (x !== exp_x[15-i] || valid !== exp_v[15-i]) begin
                    miscompares++;
                    $display("FAIL repeat_cycle%0d: got x=%b valid=%b want x=%b valid=%b",
                             i + 1, x, valid, exp_x[15-i], exp_v[15-i]);
                end
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (i == 16) begin
                vectors++;
                if (done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL repeat_done_timing: got done=%b want 1 on cycle 17", done);
                end
            end
            step();
        end
        vectors++;
        if (busy_cnt != 16) begin
            miscompares++;
            $display("FAIL repeat_busy_cycles: got %0d want 16", busy_cnt);
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL repeat_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_len_edges();
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_0101;
        launch(8'hA5, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (x !== exp_bits[7-i] || valid !== 1'b1) begin
                miscompares++;
                $display("FAIL len0_bit%0d: got x=%b valid=%b want x=%b valid=1",
                         i, x, valid, exp_bits[7-i]);
            end
            step();
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL len0_done: got done=%b want 1", done);
        end
        step();
        launch(8'h01, 4'd1, 4'd0);
        vectors++;
        if (x !== 1'b1 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL len1_bit: got x=%b valid=%b want x=1 valid=1", x, valid);
        end
        step();
        vectors++;
        if (done !== 1'b1 || x !== 1'b0) begin
            miscompares++;
            $display("FAIL len1_done: got done=%b x=%b want done=1 x=0", done, x);
        end
        step();
    endtask

    task automatic test_abort();
        int         done_cnt;
        logic [2:0] exp_bits;
        done_cnt = 0;
        exp_bits = 3'b110;
        launch(8'b0000_1011, 4'd4, 4'd1);
        step();
        vectors++;
        if (x !== 1'b0 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre_bit2: got x=%b valid=%b want x=0 valid=1", x, valid);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({S, x, valid, busy, done} !== 6'b00_0000) begin
            miscompares++;
            $display("FAIL abort_to_idle: got S=%0d x=%b valid=%b busy=%b done=%b want all 0",
                     S, x, valid, busy, done);
        end
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) done_cnt++;
            step();
        end
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt);
        end
        launch(8'b0000_0110, 4'd3, 4'd0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (x !== exp_bits[2-i] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL abort_restart_bit%0d: got x=%b busy=%b want x=%b busy=1",
                         i, x, busy, exp_bits[2-i]);
            end
            step();
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_restart_done: got done=%b want 1", done);
        end
        step();
    endtask

    task automatic test_async_reset();
        logic [2:0] exp_bits;
        exp_bits = 3'b101;
        launch(8'b0000_1011, 4'd4, 4'd1);
        for (int i = 0; i < 4; i++) step();
        vectors++;
        if (S !== 2'd2 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_in_gap: got S=%0d busy=%b want S=2 busy=1", S, busy);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        vectors++;
        if (S !== 2'd0 || busy !== 1'b0 || x !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_immediate: got S=%0d busy=%b x=%b want S=0 busy=0 x=0",
                     S, busy, x);
        end
        #1;
        RESET_N = 1'b1;
        launch(8'b0000_0101, 4'd3, 4'd0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (x !== exp_bits[2-i] || valid !== 1'b1) begin
                miscompares++;
                $display("FAIL areset_restart_bit%0d: got x=%b valid=%b want x=%b valid=1",
                         i, x, valid, exp_bits[2-i]);
            end
            step();
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_restart_done: got done=%b want 1", done);
        end
        step();
    endtask

    task automatic test_start_while_busy();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        launch(8'b0000_1011, 4'd4, 4'd0);
        pattern = 8'hF0;
        len     = 4'd8;
        rep     = 4'd3;
        start   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (x !== exp_bits[3-i] || S !== 2'd1) begin
                miscompares++;
                $display("FAIL busy_start_bit%0d: got x=%b S=%0d want x=%b S=1",
                         i, x, S, exp_bits[3-i]);
            end
            step();
        end
        vectors++;
        if (done !== 1'b1 || S !== 2'd3) begin
            miscompares++;
            $display("FAIL busy_start_done: got done=%b S=%0d want done=1 S=3", done, S);
        end
        step();
        vectors++;
        if (S !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_in_done_ignored: got S=%0d busy=%b want S=0 busy=0", S, busy);
        end
        start = 1'b0;
        step();
        vectors++;
        if (S !== 2'd0) begin
            miscompares++;
            $display("FAIL busy_start_idle_after: got S=%0d want 0", S);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_repeat_gap();
        test_len_edges();
        test_abort();
        test_async_reset();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
